reg_ref_file: RTL and testbench
===============================

Name: reg_ref_file

Overview:
Architectural register file with a per-register rename status table. It is the responder to the decode stage's register read/write requests. Each of its two read ports returns either a committed value (is_ref=0) or the ROB tag of the in-flight producer (is_ref=1). Decode allocates destinations and the commit stage retires values; flush discards all in-flight references.

Parameters:
ROB_ADDR_WIDTH, 5, width of ROB tag; also sets the ROB depth (2^ROB_ADDR_WIDTH).
DATA_WIDTH, 32, register data width; must be >= ROB_ADDR_WIDTH.
REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-low reset.
read_en_1  in  1  read port 1 enable.
read_addr_1  in  5  read port 1 register address.
read_is_ref_1  out  1  1 = read_data_1 holds a ROB tag.
read_data_1  out  DATA_WIDTH  value, or zero-extended tag.
read_en_2 / read_addr_2 / read_is_ref_2 / read_data_2: read port 2, same as port 1.
alloc_en  in  1  decode allocates a destination this cycle.
alloc_addr  in  5  destination register.
alloc_tag  in  ROB_ADDR_WIDTH  ROB entry of the producer.
commit_en  in  1  ROB retires a register write this cycle.
commit_addr  in  5  retired destination.
commit_tag  in  ROB_ADDR_WIDTH  ROB entry being retired.
commit_data  in  DATA_WIDTH  retired value.
flush  in  1  pipeline flush; clears all references.

Behaviour:
- State per register: value[DATA_WIDTH], busy[1], tag[ROB_ADDR_WIDTH].
- Reset (rst=0, asynchronous): all value, busy and tag = 0. Read outputs are combinational, so they read 0/0 while reset is held.
- Read path is combinational, zero latency. Evaluate in this priority order:
  - read_en=0 -> is_ref=0, data=0.
  - addr=0 -> is_ref=0, data=0.
  - busy[addr] and commit_en and commit_addr=addr and commit_tag=tag[addr] -> is_ref=0, data=commit_data (commit bypass).
  - busy[addr] -> is_ref=1, data={zeros, tag[addr]}.
  - otherwise -> is_ref=0, data=value[addr].
- Reads always see pre-edge state. An allocation in the same cycle never affects that cycle's reads, so "add r1,r1,r2" reads the old r1.
- Commit (posedge, commit_en=1, commit_addr≠0):
  - value[commit_addr] <= commit_data, written unconditionally.
  - busy is cleared only if tag[commit_addr]=commit_tag, i.e. no younger producer has been allocated since.
- Allocate (posedge, alloc_en=1, alloc_addr≠0, flush=0): busy <= 1, tag <= alloc_tag.
- Commit and allocate to the same address in the same cycle: value is written, busy stays 1, tag = alloc_tag (allocate wins).
- Flush (posedge, flush=1): all busy <= 0. A commit in the same cycle still writes value. An allocate in the same cycle is dropped.
- Writes to address 0 are ignored; value[0] stays 0.
- Tag uniqueness is the ROB's responsibility; the block does no overflow checking.
- Reset asserted mid-operation clears all state immediately, with no dependence on clk.

Decomposition:
- Shared include (bus.v): REG_ADDR_BUS, DATA_BUS, and a new ROB_ADDR_BUS / ROB_ADDR_WIDTH. Register-zero and $ra constants stay with the existing register-address definitions.
- One sub-module, reg_ref_read_port, is natural: the combinational priority mux above, instantiated twice. The state arrays and update logic stay in reg_ref_file.

Test Plan:
- Reset, then read r5 on both ports -> is_ref=0, data=0. Read r0 with read_en=1 -> 0/0.
- Alloc r3 tag 7; next cycle read r3 -> is_ref=1, data=0x00000007. Commit r3 tag 7 data 0xDEADBEEF in the same cycle as a read of r3 -> read returns is_ref=0, data=0xDEADBEEF. Following cycle the read returns the same from storage.
- Alloc r4 tag 2, then alloc r4 tag 9. Commit r4 tag 2 data 0x11 -> r4 stays is_ref=1, data=9, and value=0x11 is latent. Commit tag 9 data 0x22 -> reads 0x22, is_ref=0.
- Same cycle: alloc r6 tag 4 and commit r6 data 0x55 (tag matching the old producer) -> r6 is_ref=1, data=4. Read r6 during that cycle sees the commit bypass (0x55, is_ref=0).
- Alloc r8 tag 1 and r9 tag 3, then flush together with alloc r10 tag 5 and commit r8 tag 1 data 0xAA -> r8=0xAA, r9=old value, r10 not busy. All ports report is_ref=0.
- Alloc r2 tag 6, then pulse rst low between clock edges -> reads of r2 drop immediately to is_ref=0, data=0.

Source files
------------

// File: rtl/reg_ref_file_pkg.sv
// rtl/reg_ref_file_pkg.sv - shared widths, register-address type and helpers for the reference register file
package reg_ref_file_pkg;

    // Register-address definitions (register zero lives here with the address type)
    localparam int REG_ADDR_WIDTH = 5;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    // Defaults for the data bus and the ROB tag bus
    localparam int DATA_WIDTH_DEF     = 32;
    localparam int ROB_ADDR_WIDTH_DEF = 5;
    localparam int REG_COUNT_DEF      = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_ref_file_if.sv
// rtl/reg_ref_file_if.sv - decode/commit request bus of the reference register file
//
// master: decode/commit side (drives reads, allocations, commits, flush)
// slave : register file (returns is_ref/data per read port)
interface reg_ref_file_if
    import reg_ref_file_pkg::*;
#(
    parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF
);
    logic                      read_en_1;
    reg_addr_t                 read_addr_1;
    logic                      read_is_ref_1;
    logic [DATA_WIDTH-1:0]     read_data_1;

    logic                      read_en_2;
    reg_addr_t                 read_addr_2;
    logic                      read_is_ref_2;
    logic [DATA_WIDTH-1:0]     read_data_2;

    logic                      alloc_en;
    reg_addr_t                 alloc_addr;
    logic [ROB_ADDR_WIDTH-1:0] alloc_tag;

    logic                      commit_en;
    reg_addr_t                 commit_addr;
    logic [ROB_ADDR_WIDTH-1:0] commit_tag;
    logic [DATA_WIDTH-1:0]     commit_data;

    logic                      flush;

    modport master (
        output read_en_1, read_addr_1, read_en_2, read_addr_2,
        output alloc_en, alloc_addr, alloc_tag,
        output commit_en, commit_addr, commit_tag, commit_data,
        output flush,
        input  read_is_ref_1, read_data_1, read_is_ref_2, read_data_2
    );

    modport slave (
        input  read_en_1, read_addr_1, read_en_2, read_addr_2,
        input  alloc_en, alloc_addr, alloc_tag,
        input  commit_en, commit_addr, commit_tag, commit_data,
        input  flush,
        output read_is_ref_1, read_data_1, read_is_ref_2, read_data_2
    );

endinterface

// File: rtl/reg_ref_read_port.sv
// rtl/reg_ref_read_port.sv - combinational priority mux for one register read port
//
// Inputs : read_en/read_addr, the addressed register's busy/tag/value, the commit bus
// Outputs: is_ref (data carries a ROB tag), data (value or zero-extended tag)
module reg_ref_read_port
    import reg_ref_file_pkg::*;
#(
    parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
    input  logic                      read_en,
    input  reg_addr_t                 read_addr,
    input  logic                      busy,
    input  logic [ROB_ADDR_WIDTH-1:0] tag,
    input  logic [DATA_WIDTH-1:0]     value,
    input  logic                      commit_en,
    input  reg_addr_t                 commit_addr,
    input  logic [ROB_ADDR_WIDTH-1:0] commit_tag,
    input  logic [DATA_WIDTH-1:0]     commit_data,
    output logic                      is_ref,
    output logic [DATA_WIDTH-1:0]     data
);

    always_comb begin
        is_ref = 1'b0;
        data   = '0;
        if (read_en && !is_zero_reg(read_addr)) begin
            if (busy && commit_en && commit_addr == read_addr && commit_tag == tag) begin
                // Producer retiring this very cycle: forward its value instead of the tag
                data = commit_data;
            end else if (busy) begin
                is_ref = 1'b1;
                data   = DATA_WIDTH'(tag);
            end else begin
                data = value;
            end
        end
    end

endmodule

// File: rtl/reg_ref_file.sv
// rtl/reg_ref_file.sv - architectural register file with per-register rename status
//
// Ports: clk, rst (async active-low), bus (slave modport of reg_ref_file_if:
//        two read ports, allocate, commit, flush)
module reg_ref_file
    import reg_ref_file_pkg::*;
#(
    parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_COUNT      = REG_COUNT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    reg_ref_file_if.slave bus
);

    logic [DATA_WIDTH-1:0]     value_q [REG_COUNT];
    logic [ROB_ADDR_WIDTH-1:0] tag_q   [REG_COUNT];
    logic [REG_COUNT-1:0]      busy_q;

    // Later assignments in this block take precedence: commit clears busy,
    // flush overrides that, and a surviving allocation overrides both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            if (bus.commit_en && !is_zero_reg(bus.commit_addr)) begin
                value_q[bus.commit_addr] <= bus.commit_data;
                // A younger producer keeps the register busy
                if (tag_q[bus.commit_addr] == bus.commit_tag)
                    busy_q[bus.commit_addr] <= 1'b0;
            end
            if (bus.flush)
                busy_q <= '0;
            if (bus.alloc_en && !bus.flush && !is_zero_reg(bus.alloc_addr)) begin
                busy_q[bus.alloc_addr] <= 1'b1;
                tag_q[bus.alloc_addr]  <= bus.alloc_tag;
            end
        end
    end

    reg_ref_read_port #(
        .ROB_ADDR_WIDTH (ROB_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_read_port_1 (
        .read_en     (bus.read_en_1),
        .read_addr   (bus.read_addr_1),
        .busy        (busy_q[bus.read_addr_1]),
        .tag         (tag_q[bus.read_addr_1]),
        .value       (value_q[bus.read_addr_1]),
        .commit_en   (bus.commit_en),
        .commit_addr (bus.commit_addr),
        .commit_tag  (bus.commit_tag),
        .commit_data (bus.commit_data),
        .is_ref      (bus.read_is_ref_1),
        .data        (bus.read_data_1)
    );

    reg_ref_read_port #(
        .ROB_ADDR_WIDTH (ROB_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_read_port_2 (
        .read_en     (bus.read_en_2),
        .read_addr   (bus.read_addr_2),
        .busy        (busy_q[bus.read_addr_2]),
        .tag         (tag_q[bus.read_addr_2]),
        .value       (value_q[bus.read_addr_2]),
        .commit_en   (bus.commit_en),
        .commit_addr (bus.commit_addr),
        .commit_tag  (bus.commit_tag),
        .commit_data (bus.commit_data),
        .is_ref      (bus.read_is_ref_2),
        .data        (bus.read_data_2)
    );

endmodule

// File: tb/tb_reg_ref_file.sv
// tb/tb_reg_ref_file.sv - table-driven, scoreboarded bench for reg_ref_file
module tb_reg_ref_file;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_ref_file_if #(.ROB_ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    reg_ref_file #(.ROB_ADDR_WIDTH(5), .DATA_WIDTH(32), .REG_COUNT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        re1; logic [4:0] ra1;
        logic        re2; logic [4:0] ra2;
        logic        ae;  logic [4:0] aa; logic [4:0] at;
        logic        ce;  logic [4:0] ca; logic [4:0] ct; logic [31:0] cd;
        logic        fl;
        logic        x1;  logic [31:0] d1;
        logic        x2;  logic [31:0] d2;
    } vec_t;

    typedef struct {
        int          id;
        logic        x1; logic [31:0] d1;
        logic        x2; logic [31:0] d2;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2,
                       input logic ae, input logic [4:0] aa, input logic [4:0] at,
                       input logic ce, input logic [4:0] ca, input logic [4:0] ct, input logic [31:0] cd,
                       input logic fl, input logic x1, input logic [31:0] d1,
                       input logic x2, input logic [31:0] d2);
        vec_t v;
        v.re1 = re1; v.ra1 = ra1; v.re2 = re2; v.ra2 = ra2;
        v.ae = ae; v.aa = aa; v.at = at;
        v.ce = ce; v.ca = ca; v.ct = ct; v.cd = cd; v.fl = fl;
        v.x1 = x1; v.d1 = d1; v.x2 = x2; v.d2 = d2;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.read_en_1 = v.re1; bus.read_addr_1 = v.ra1;
        bus.read_en_2 = v.re2; bus.read_addr_2 = v.ra2;
        bus.alloc_en = v.ae; bus.alloc_addr = v.aa; bus.alloc_tag = v.at;
        bus.commit_en = v.ce; bus.commit_addr = v.ca; bus.commit_tag = v.ct; bus.commit_data = v.cd;
        bus.flush = v.fl;
    endtask

    task automatic expect_push(input int id, input logic x1, input logic [31:0] d1,
                               input logic x2, input logic [31:0] d2);
        exp_t e;
        e.id = id; e.x1 = x1; e.d1 = d1; e.x2 = x2; e.d2 = d2;
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, id, act, req);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        cmp("is_ref_1", e.id, 32'(bus.read_is_ref_1), 32'(e.x1));
        cmp("data_1",   e.id, bus.read_data_1,        e.d1);
        cmp("is_ref_2", e.id, 32'(bus.read_is_ref_2), 32'(e.x2));
        cmp("data_2",   e.id, bus.read_data_2,        e.d2);
    endtask

    initial begin
        vec_t idle;
        idle = '{default: '0};
        drive(idle);

        // Reset held: reads of r5 are 0/0 regardless of enable
        idle.re1 = 1'b1; idle.ra1 = 5'd5; idle.re2 = 1'b1; idle.ra2 = 5'd5;
        drive(idle);
        #2;
        expect_push(-1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_pop();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        //   re1 ra1 re2 ra2  ae aa at   ce ca ct cd           fl  x1 d1            x2 d2
        add(1, 5,  1, 5,   0, 0, 0,   0, 0, 0,  32'h0,      0,  0, 32'h0,        0, 32'h0);        // 0 reset read
        add(1, 0,  1, 5,   0, 0, 0,   0, 0, 0,  32'h0,      0,  0, 32'h0,        0, 32'h0);        // 1 r0
        add(1, 3,  0, 3,   1, 3, 7,   0, 0, 0,  32'h0,      0,  0, 32'h0,        0, 32'h0);        // 2 alloc r3 t7
        add(1, 3,  1, 3,   0, 0, 0,   0, 0, 0,  32'h0,      0,  1, 32'h7,        1, 32'h7);        // 3 r3 ref 7
        add(1, 3,  0, 3,   0, 0, 0,   1, 3, 7,  32'hDEADBEEF,0, 0, 32'hDEADBEEF, 0, 32'h0);        // 4 bypass
        add(1, 3,  1, 3,   0, 0, 0,   0, 0, 0,  32'h0,      0,  0, 32'hDEADBEEF, 0, 32'hDEADBEEF); // 5 stored
        add(1, 4,  0, 0,   1, 4, 2,   0, 0, 0,  32'h0,      0,  0, 32'h0,        0, 32'h0);        // 6 alloc r4 t2
        add(1, 4,  0, 0,   1, 4, 9,   0, 0, 0,  32'h0,      0,  1, 32'h2,        0, 32'h0);        // 7 alloc r4 t9
        add(1, 4,  1, 3,   0, 0, 0,   1, 4, 2,  32'h11,     0,  1, 32'h9,        0, 32'hDEADBEEF); // 8 stale commit
        add(1, 4,  1, 4,   0, 0, 0,   0, 0, 0,  32'h0,      0,  1, 32'h9,        1, 32'h9);        // 9 still ref 9
        add(1, 4,  0, 0,   0, 0, 0,   1, 4, 9,  32'h22,     0,  0, 32'h22,       0, 32'h0);        // 10 bypass 0x22
        add(1, 4,  1, 4,   0, 0, 0,   0, 0, 0,  32'h0,      0,  0, 32'h22,       0, 32'h22);       // 11
        add(1, 6,  0, 0,   1, 6, 12,  0, 0, 0,  32'h0,      0,  0, 32'h0,        0, 32'h0);        // 12 alloc r6 t12
        add(1, 6,  1, 6,   1, 6, 4,   1, 6, 12, 32'h55,     0,  0, 32'h55,       0, 32'h55);       // 13 alloc+commit
        add(1, 6,  1, 6,   0, 0, 0,   0, 0, 0,  32'h0,      0,  1, 32'h4,        1, 32'h4);        // 14 alloc wins
        add(1, 8,  1, 9,   1, 8, 1,   1, 9, 0,  32'h99,     0,  0, 32'h0,        0, 32'h0);        // 15 r9 old value
        add(1, 8,  1, 9,   1, 9, 3,   0, 0, 0,  32'h0,      0,  1, 32'h1,        0, 32'h99);       // 16 alloc r9 t3
        add(1, 8,  1, 9,   1, 10, 5,  1, 8, 1,  32'hAA,     1,  0, 32'hAA,       1, 32'h3);        // 17 flush
        add(1, 8,  1, 9,   0, 0, 0,   0, 0, 0,  32'h0,      0,  0, 32'hAA,       0, 32'h99);       // 18
        add(1, 10, 1, 6,   0, 0, 0,   0, 0, 0,  32'h0,      0,  0, 32'h0,        0, 32'h55);       // 19 r10 dropped
        add(1, 0,  0, 0,   1, 0, 3,   1, 0, 0,  32'hFF,     0,  0, 32'h0,        0, 32'h0);        // 20 r0 writes
        add(1, 0,  1, 3,   0, 0, 0,   0, 0, 0,  32'h0,      0,  0, 32'h0,        0, 32'hDEADBEEF); // 21
        add(1, 2,  0, 0,   1, 2, 6,   0, 0, 0,  32'h0,      0,  0, 32'h0,        0, 32'h0);        // 22 alloc r2 t6
        add(1, 2,  1, 2,   0, 0, 0,   0, 0, 0,  32'h0,      0,  1, 32'h6,        1, 32'h6);        // 23

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            expect_push(i, vecs[i].x1, vecs[i].d1, vecs[i].x2, vecs[i].d2);
            #2;
            check_pop();
        end

        // Mid-cycle reset pulse: r2 drops at once, without a clock edge
        @(negedge clk);
        idle = '{default: '0};
        idle.re1 = 1'b1; idle.ra1 = 5'd2; idle.re2 = 1'b1; idle.ra2 = 5'd2;
        drive(idle);
        expect_push(100, 1'b1, 32'h6, 1'b1, 32'h6);
        #1;
        check_pop();
        rst = 1'b0;
        expect_push(101, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check_pop();
        rst = 1'b1;

        // After the pulse every register, committed values included, is cleared
        @(negedge clk);
        idle.ra2 = 5'd3;
        drive(idle);
        expect_push(102, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        check_pop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
